// File: rtl/bf_fetch_unit_if.sv
// Program-ROM read port and opcode valid/ready handshake between the fetch unit and the core.
// master = fetch unit side, slave = ROM/core side.
interface bf_fetch_unit_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op_code;
   logic              cell_zero;

   modport master (
      output rom_addr, op_valid, op_code,
      input  rom_data, op_ready, cell_zero
   );

   modport slave (
      input  rom_addr, op_valid, op_code,
      output rom_data, op_ready, cell_zero
   );
endinterface

// File: rtl/bf_fetch_unit.sv
// Brainfuck fetch/decode unit with ROM-scanning bracket resolution.
// Optional macro BF_FETCH_COMMENT_SKIP_EN: skip non-command bytes instead of flagging an error.
module bf_fetch_unit #(
   parameter int ADDR_W  = 4,
   parameter int DEPTH_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   bf_fetch_unit_if.master   bus,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              error
);

   typedef enum logic [3:0] {
      ST_FETCH        = 4'd0,
      ST_EVAL         = 4'd1,
      ST_ISSUE        = 4'd2,
      ST_SCAN_F_FETCH = 4'd3,
      ST_SCAN_F_EVAL  = 4'd4,
      ST_SCAN_B_FETCH = 4'd5,
      ST_SCAN_B_EVAL  = 4'd6,
      ST_HALT         = 4'd7,
      ST_ERROR        = 4'd8
   } state_t;

   localparam logic [2:0]         OP_OPEN    = 3'd6;
   localparam logic [2:0]         OP_CLOSE   = 3'd7;
   localparam logic [7:0]         CH_OPEN    = 8'h5B;
   localparam logic [7:0]         CH_CLOSE   = 8'h5D;
   localparam logic [7:0]         CH_END     = 8'h00;
   localparam logic [ADDR_W-1:0]  PC_ZERO    = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0]  PC_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0]  PC_MAX     = {ADDR_W{1'b1}};
   localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
   localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_W-1:0] DEPTH_MAX  = {DEPTH_W{1'b1}};

   // Returns {is_command, opcode}.
   function automatic logic [3:0] decode_cmd(input logic [7:0] b);
      logic [3:0] r;
      case (b)
         8'h2B:   r = 4'b1_000;
         8'h2D:   r = 4'b1_001;
         8'h3E:   r = 4'b1_010;
         8'h3C:   r = 4'b1_011;
         8'h2E:   r = 4'b1_100;
         8'h2C:   r = 4'b1_101;
         8'h5B:   r = 4'b1_110;
         8'h5D:   r = 4'b1_111;
         default: r = 4'b0_000;
      endcase
      return r;
   endfunction

   state_t             state_r, state_s;
   logic [ADDR_W-1:0]  pc_r, pc_s, pc_inc_s, pc_dec_s;
   logic [DEPTH_W-1:0] depth_r, depth_s;
   logic [2:0]         op_code_r, op_code_s;
   logic [3:0]         dec_s;
   logic               pc_last_s, pc_first_s, depth_zero_s, depth_full_s;
   logic               op_valid_s, halted_s, error_s;

   assign dec_s        = decode_cmd(bus.rom_data);
   assign pc_inc_s     = pc_r + PC_ONE;
   assign pc_dec_s     = pc_r - PC_ONE;
   assign pc_last_s    = (pc_r == PC_MAX);
   assign pc_first_s   = (pc_r == PC_ZERO);
   assign depth_zero_s = (depth_r == DEPTH_ZERO);
   assign depth_full_s = (depth_r == DEPTH_MAX);

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_FETCH;
         pc_r      <= PC_ZERO;
         depth_r   <= DEPTH_ZERO;
         op_code_r <= 3'd0;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         depth_r   <= depth_s;
         op_code_r <= op_code_s;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_s   = state_r;
      pc_s      = pc_r;
      depth_s   = depth_r;
      op_code_s = op_code_r;
      case (state_r)
         ST_FETCH:        state_s = ST_EVAL;
         ST_SCAN_F_FETCH: state_s = ST_SCAN_F_EVAL;
         ST_SCAN_B_FETCH: state_s = ST_SCAN_B_EVAL;
         ST_EVAL: begin
            if (dec_s[3]) begin
               op_code_s = dec_s[2:0];
               state_s   = ST_ISSUE;
            end else if (bus.rom_data == CH_END) begin
               state_s = ST_HALT;
            end else begin
`ifdef BF_FETCH_COMMENT_SKIP_EN
               if (pc_last_s) begin
                  state_s = ST_HALT;
               end else begin
                  pc_s    = pc_inc_s;
                  state_s = ST_FETCH;
               end
`else
               state_s = ST_ERROR;
`endif
            end
         end
         ST_ISSUE: begin
            if (!bus.op_ready) begin
               state_s = ST_ISSUE;
            end else if ((op_code_r == OP_OPEN) && bus.cell_zero) begin
               depth_s = DEPTH_ZERO;
               if (pc_last_s) begin
                  state_s = ST_ERROR;
               end else begin
                  pc_s    = pc_inc_s;
                  state_s = ST_SCAN_F_FETCH;
               end
            end else if ((op_code_r == OP_CLOSE) && !bus.cell_zero) begin
               depth_s = DEPTH_ZERO;
               if (pc_first_s) begin
                  state_s = ST_ERROR;
               end else begin
                  pc_s    = pc_dec_s;
                  state_s = ST_SCAN_B_FETCH;
               end
            end else if (pc_last_s) begin
               state_s = ST_HALT;
            end else begin
               pc_s    = pc_inc_s;
               state_s = ST_FETCH;
            end
         end
         ST_SCAN_F_EVAL: begin
            if (bus.rom_data == CH_END) begin
               state_s = ST_ERROR;
            end else if ((bus.rom_data == CH_CLOSE) && depth_zero_s) begin
               // Match found: execution resumes just past the closing bracket.
               if (pc_last_s) begin
                  state_s = ST_HALT;
               end else begin
                  pc_s    = pc_inc_s;
                  state_s = ST_FETCH;
               end
            end else if (((bus.rom_data == CH_OPEN) && depth_full_s) || pc_last_s) begin
               state_s = ST_ERROR;
            end else begin
               pc_s    = pc_inc_s;
               state_s = ST_SCAN_F_FETCH;
               if (bus.rom_data == CH_OPEN) begin
                  depth_s = depth_r + DEPTH_ONE;
               end else if (bus.rom_data == CH_CLOSE) begin
                  depth_s = depth_r - DEPTH_ONE;
               end else begin
                  depth_s = depth_r;
               end
            end
         end
         ST_SCAN_B_EVAL: begin
            if ((bus.rom_data == CH_OPEN) && depth_zero_s) begin
               // Resume at the first command inside the loop body.
               if (pc_last_s) begin
                  state_s = ST_HALT;
               end else begin
                  pc_s    = pc_inc_s;
                  state_s = ST_FETCH;
               end
            end else if (((bus.rom_data == CH_CLOSE) && depth_full_s) || pc_first_s) begin
               state_s = ST_ERROR;
            end else begin
               pc_s    = pc_dec_s;
               state_s = ST_SCAN_B_FETCH;
               if (bus.rom_data == CH_CLOSE) begin
                  depth_s = depth_r + DEPTH_ONE;
               end else if (bus.rom_data == CH_OPEN) begin
                  depth_s = depth_r - DEPTH_ONE;
               end else begin
                  depth_s = depth_r;
               end
            end
         end
         ST_HALT:  state_s = ST_HALT;
         ST_ERROR: state_s = ST_ERROR;
         default:  state_s = ST_ERROR;
      endcase
   end

   // Output decode, driven straight from the state register.
   always_comb begin
      op_valid_s = 1'b0;
      halted_s   = 1'b0;
      error_s    = 1'b0;
      case (state_r)
         ST_ISSUE: op_valid_s = 1'b1;
         ST_HALT:  halted_s   = 1'b1;
         ST_ERROR: error_s    = 1'b1;
         default: begin
            op_valid_s = 1'b0;
            halted_s   = 1'b0;
            error_s    = 1'b0;
         end
      endcase
   end

   assign bus.rom_addr = pc_r;
   assign bus.op_valid = op_valid_s;
   assign bus.op_code  = op_code_r;
   assign pc           = pc_r;
   assign halted       = halted_s;
   assign error        = error_s;

endmodule

// File: tb/tb_bf_fetch_unit.sv
// Scoreboard bench for bf_fetch_unit: expected ops are queued per program and
// popped as the unit presents them; a behavioural synchronous ROM feeds the unit.
module tb_bf_fetch_unit;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] pc;
      logic       cz;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] pc;
   logic       halted, error;
   logic [7:0] rom [16];
   exp_t       sb_q [$];
   int         vec_cnt = 0;
   int         err_cnt = 0;
   int         cyc = 0;
   int         acc_cnt = 0;

   bf_fetch_unit_if #(.ADDR_W(4)) bus ();

   bf_fetch_unit #(.ADDR_W(4), .DEPTH_W(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .pc     (pc),
      .halted (halted),
      .error  (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bus.rom_data <= rom[bus.rom_addr];
      cyc <= cyc + 1;
      if (bus.op_valid && bus.op_ready) acc_cnt <= acc_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
   endtask

   task automatic push(input logic [2:0] op, input logic [3:0] p, input logic cz);
      exp_t e;
      e.op = op; e.pc = p; e.cz = cz;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      bus.op_ready  = 1'b1;
      bus.cell_zero = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Pops one scoreboard entry per presented op until the unit stops.
   task automatic run_ops(input int budget, input int gap);
      exp_t e;
      int   last = -1;
      for (int c = 0; c < budget; c++) begin
         if (halted || error) break;
         if (bus.op_valid) begin
            if (sb_q.size() == 0) begin
               check_eq("extra_op", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check_eq("op_code", 32'(bus.op_code), 32'(e.op));
               check_eq("op_pc", 32'(pc), 32'(e.pc));
               bus.cell_zero = e.cz;
               if (gap > 0 && last >= 0) check_eq("op_gap", 32'(cyc - last), 32'(gap));
               last = cyc;
            end
         end
         @(negedge clk);
      end
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      check_eq("stopped", 32'(halted || error), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      int c = 0;
      while (!bus.op_valid && c < budget) begin
         @(negedge clk);
         c++;
      end
      check_eq("wait_valid", 32'(bus.op_valid), 32'd1);
   endtask

   task automatic check_end(input string tag, input logic h, input logic er, input logic [3:0] p);
      check_eq({tag, "_halted"}, 32'(halted), 32'(h));
      check_eq({tag, "_error"}, 32'(error), 32'(er));
      check_eq({tag, "_valid"}, 32'(bus.op_valid), 32'd0);
      check_eq({tag, "_pc"}, 32'(pc), 32'(p));
   endtask

   initial begin
      int a0;
      bus.op_ready  = 1'b1;
      bus.cell_zero = 1'b0;
      clear_rom();

      // Reset values, first-op latency, straight-line program.
      rom[0] = 8'h2B; rom[1] = 8'h2B; rom[2] = 8'h3E; rom[3] = 8'h2D; rom[4] = 8'h2D;
      @(negedge clk);
      check_eq("rst_valid", 32'(bus.op_valid), 32'd0);
      check_eq("rst_addr", 32'(bus.rom_addr), 32'd0);
      check_eq("rst_code", 32'(bus.op_code), 32'd0);
      check_end("rst", 1'b0, 1'b0, 4'd0);
      do_reset();
      @(negedge clk);
      check_eq("lat_edge1", 32'(bus.op_valid), 32'd0);
      @(negedge clk);
      check_eq("lat_edge2", 32'(bus.op_valid), 32'd1);
      push(3'd0, 4'd0, 1'b0); push(3'd0, 4'd1, 1'b0); push(3'd2, 4'd2, 1'b0);
      push(3'd1, 4'd3, 1'b0); push(3'd1, 4'd4, 1'b0);
      run_ops(200, 3);
      check_end("straight", 1'b1, 1'b0, 4'd5);

      // Backward jump taken once, then fall through.
      clear_rom();
      rom[0] = 8'h2B; rom[1] = 8'h5B; rom[2] = 8'h2D; rom[3] = 8'h5D;
      do_reset();
      push(3'd0, 4'd0, 1'b0); push(3'd6, 4'd1, 1'b0); push(3'd1, 4'd2, 1'b0);
      push(3'd7, 4'd3, 1'b0); push(3'd1, 4'd2, 1'b0); push(3'd7, 4'd3, 1'b1);
      run_ops(300, 0);
      check_end("loop", 1'b1, 1'b0, 4'd4);

      // Nested forward skip.
      clear_rom();
      rom[0] = 8'h5B; rom[1] = 8'h5B; rom[2] = 8'h2B; rom[3] = 8'h5D; rom[4] = 8'h5D; rom[5] = 8'h2D;
      do_reset();
      push(3'd6, 4'd0, 1'b1); push(3'd1, 4'd5, 1'b0);
      run_ops(300, 0);
      check_end("nest", 1'b1, 1'b0, 4'd6);

      // Backpressure on a single '+'.
      clear_rom();
      rom[0] = 8'h2B;
      do_reset();
      bus.op_ready = 1'b0;
      wait_valid(10);
      a0 = acc_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("bp_valid", 32'(bus.op_valid), 32'd1);
         check_eq("bp_code", 32'(bus.op_code), 32'd0);
         check_eq("bp_pc", 32'(pc), 32'd0);
      end
      check_eq("bp_no_acc", 32'(acc_cnt - a0), 32'd0);
      bus.op_ready = 1'b1;
      for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
      check_eq("bp_one_acc", 32'(acc_cnt - a0), 32'd1);
      check_end("bp", 1'b1, 1'b0, 4'd1);

      // Unterminated forward scan.
      clear_rom();
      rom[0] = 8'h5B; rom[1] = 8'h2B;
      do_reset();
      push(3'd6, 4'd0, 1'b1);
      run_ops(100, 0);
      check_end("unmatched", 1'b0, 1'b1, 4'd2);

      // Non-command byte.
      clear_rom();
      rom[0] = 8'h2B; rom[1] = 8'h41;
      do_reset();
      push(3'd0, 4'd0, 1'b0);
      run_ops(100, 0);
`ifdef BF_FETCH_COMMENT_SKIP_EN
      check_end("comment", 1'b1, 1'b0, 4'd2);
`else
      check_end("comment", 1'b0, 1'b1, 4'd1);
`endif

      // Reset while an op is pending.
      clear_rom();
      rom[0] = 8'h5B; rom[1] = 8'h2B; rom[2] = 8'h2B; rom[3] = 8'h2B; rom[4] = 8'h2B; rom[5] = 8'h5D;
      do_reset();
      bus.op_ready = 1'b0;
      wait_valid(10);
      reset = 1'b1;
      #1;
      check_eq("rst_issue_valid", 32'(bus.op_valid), 32'd0);
      @(negedge clk);

      // Reset during a forward scan, then a full rerun from pc 0.
      do_reset();
      bus.op_ready = 1'b0;
      wait_valid(10);
      bus.cell_zero = 1'b1;
      bus.op_ready  = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("scan_pc", 32'(pc), 32'd2);
      reset = 1'b1;
      #1;
      check_eq("rst_scan_valid", 32'(bus.op_valid), 32'd0);
      check_eq("rst_scan_addr", 32'(bus.rom_addr), 32'd0);
      check_eq("rst_scan_code", 32'(bus.op_code), 32'd0);
      check_end("rst_scan", 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.cell_zero = 1'b0;
      push(3'd6, 4'd0, 1'b0); push(3'd0, 4'd1, 1'b0); push(3'd0, 4'd2, 1'b0);
      push(3'd0, 4'd3, 1'b0); push(3'd0, 4'd4, 1'b0); push(3'd7, 4'd5, 1'b1);
      run_ops(300, 3);
      check_end("rerun", 1'b1, 1'b0, 4'd6);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/bf_fetch_unit.md
# bf_fetch_unit

Instruction fetch and bracket-resolution unit for the brainfuck processor. It drives the address of the synchronous program ROM, consumes the returned bytes, and decodes the eight command characters into 3-bit opcodes. Opcodes are handed to the execution core over a valid/ready handshake. The unit also resolves `[` / `]` jumps by scanning the ROM with a nesting counter, so the core never handles program-counter control flow.

## Interface
Parameters:
- ADDR_W, 4, program ROM address width; program length is 2^ADDR_W bytes.
- DEPTH_W, 4, width of the bracket-nesting counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rom_addr  output  ADDR_W  ROM address; equals the pc register.
- rom_data  input  8  ROM byte; valid the cycle after rom_addr is presented (1-cycle synchronous read).
- op_valid  output  1  op_code holds a command for the core.
- op_ready  input  1  core accepts op_code this cycle.
- op_code  output  3  command: 0 `+`, 1 `-`, 2 `>`, 3 `<`, 4 `.`, 5 `,`, 6 `[`, 7 `]`.
- cell_zero  input  1  current tape cell is zero; sampled only on an accepted `[` or `]`.
- pc  output  ADDR_W  address of the current or presented command.
- halted  output  1  end of program reached; sticky until reset.
- error  output  1  unmatched bracket, depth overflow, or illegal byte; sticky until reset.

## Operation
- States: FETCH, EVAL, ISSUE, SCAN_F_FETCH, SCAN_F_EVAL, SCAN_B_FETCH, SCAN_B_EVAL, HALT, ERROR.
- FETCH: rom_addr = pc. Always goes to EVAL.
- EVAL: classifies rom_data.
  - Command byte: latch op_code and go to ISSUE.
  - 0x00: go to HALT.
  - Any other byte: handled per Configuration.
- ISSUE: op_valid = 1, with op_code held stable. Nothing else happens until op_valid & op_ready. On that handshake:
  - `[` with cell_zero = 1: depth ← 0, pc ← pc+1, go to SCAN_F_FETCH.
  - `]` with cell_zero = 0: depth ← 0, pc ← pc−1, go to SCAN_B_FETCH.
  - Otherwise: pc ← pc+1, go to FETCH.
- Forward scan (one FETCH/EVAL pair per byte):
  - `[`: depth+1.
  - `]` with depth = 0: match; pc ← pc+1, go to FETCH.
  - `]` with depth ≠ 0: depth−1.
  - Other bytes: ignored (no comment check during scans).
  - 0x00: ERROR.
- Backward scan (same structure, mirrored):
  - `]`: depth+1.
  - `[` with depth = 0: match; pc ← pc+1, go to FETCH.
  - `[` with depth ≠ 0: depth−1.
  - pc = 0 with no match: ERROR.
- Depth increment at all-ones: ERROR.
- Address end: pc+1 from 2^ADDR_W−1 in any path (normal advance or forward scan) goes to HALT during normal fetch and to ERROR during a forward scan. The pc never wraps.
- HALT: halted = 1, op_valid = 0. ERROR: error = 1, op_valid = 0. Both are terminal until reset.

## Timing
- Reset values: rom_addr 0, pc 0, op_valid 0, op_code 0, halted 0, error 0, depth 0, state FETCH.
- Reset is asynchronous. Asserting it mid-ISSUE or mid-scan drops op_valid immediately, and the pending op is lost.
- First op_valid rises after the 2nd rising edge following reset release.
- Each command costs FETCH + EVAL + ISSUE = 3 cycles when op_ready is held high.
- Each scanned or skipped byte costs 2 cycles.
- op_code and pc are stable while op_valid = 1 and op_ready = 0.
- halted rises 2 cycles after the pc reaches the 0x00 byte.
- op_ready with op_valid = 0 has no effect.

## Configuration
- BF_FETCH_COMMENT_SKIP_EN defined: a non-command, non-zero byte in EVAL sets pc ← pc+1 and returns to FETCH, so comments are transparent.
- BF_FETCH_COMMENT_SKIP_EN undefined: such a byte sends the unit to ERROR with pc pointing at the byte.

## Test plan
- ROM 2B 2B 3E 2D 2D 00, op_ready = 1 → ops 0,0,2,1,1 at 3-cycle spacing, pc 0..4; then halted = 1 with op_valid = 0.
- ROM 2B 5B 2D 5D 00. Answer cell_zero = 0 on the first `]` and 1 on the second → sequence 0,6,1,7,1,7.
  - After each `]` with cell_zero = 0, the next op is at pc 2.
  - Run ends halted.
- ROM 5B 5B 2B 5D 5D 2D 00, cell_zero = 1 on the first `[` → next op is `-` at pc 5. The nested scan depth reaches 1 and returns to 0.
- Backpressure: op_ready = 0 for 5 cycles on a `+` → op_valid and op_code held for all 5 cycles; exactly one acceptance once op_ready rises.
- Errors: ROM 5B 2B 00 with cell_zero = 1 → error = 1, halted = 0. With the macro undefined, ROM 2B 41 → error = 1 at pc 1.
- Reset asserted during a forward scan → all outputs return to reset values the same cycle. After release, refetch starts at pc 0.
